// File: rtl/if_id_pkg.sv
// rtl/if_id_pkg.sv - shared defaults for the IF/ID pipeline register
//
// Purpose: holds the default instruction and PC widths and the bubble
//          (NOP) encoding used by if_id and its pipe_reg instances.
// Ports:   none (package).
package if_id_pkg;

    localparam int IF_ID_INSTR_W = 19;
    localparam int IF_ID_PC_W    = 8;

    // Bubble encoding: an all-zero instruction word.
    localparam logic [IF_ID_INSTR_W-1:0] IF_ID_NOP_INSTR = '0;

endpackage

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - generic pipeline field register with reset, clear and load
//
// Purpose: one pipeline field. Priority is reset > clear > load > hold.
// Ports:
//   clk          in   1      rising-edge clock
//   reset        in   1      synchronous, active-high; loads RST_VAL
//   i_load       in   1      capture i_d
//   i_clear      in   1      capture i_clear_val (wins over i_load)
//   i_clear_val  in   WIDTH  value loaded by a clear
//   i_d          in   WIDTH  data to capture
//   o_q          out  WIDTH  registered field, driven straight from the flop
module pipe_reg #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_clear_val,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RST_VAL;
        end else if (i_clear) begin
            r_q <= i_clear_val;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/if_id.sv
// rtl/if_id.sv - IF/ID pipeline register with stall and optional flush
//
// Purpose: registers the fetched instruction and PC+1 for the ID stage.
//          Priority is reset > flush > write > hold. The flush input only
//          exists when the macro IF_ID_FLUSH_EN is defined.
// Ports:
//   clk               in   1        rising-edge clock
//   reset             in   1        synchronous, active-high
//   next_instruction  in   INSTR_W  instruction fetched in IF
//   pc_plus_one_IF    in   PC_W     IF-stage PC+1
//   IF_IDwrite        in   1        load enable; 0 = stall/hold
//   IF_IDflush        in   1        bubble insert (IF_ID_FLUSH_EN only)
//   instruction       out  INSTR_W  registered instruction for ID
//   pc_plus_one_ID    out  PC_W     registered PC+1 for ID
//   valid_ID          out  1        ID holds a real instruction
module if_id
    import if_id_pkg::*;
#(
    parameter int                 INSTR_W   = IF_ID_INSTR_W,
    parameter int                 PC_W      = IF_ID_PC_W,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(IF_ID_NOP_INSTR)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] next_instruction,
    input  logic [PC_W-1:0]    pc_plus_one_IF,
    input  logic               IF_IDwrite,
`ifdef IF_ID_FLUSH_EN
    input  logic               IF_IDflush,
`endif
    output logic [INSTR_W-1:0] instruction,
    output logic [PC_W-1:0]    pc_plus_one_ID,
    output logic               valid_ID
);

    logic w_flush;
    logic w_load;

`ifdef IF_ID_FLUSH_EN
    assign w_flush = IF_IDflush;
`else
    assign w_flush = 1'b0;
`endif

    // A flush must not let PC+1 advance, so load is masked by flush here
    // rather than relying on the clear priority inside pipe_reg.
    assign w_load = IF_IDwrite & ~w_flush;

    pipe_reg #(
        .WIDTH   (INSTR_W),
        .RST_VAL (NOP_INSTR)
    ) u_instr_reg (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_clear     (w_flush),
        .i_clear_val (NOP_INSTR),
        .i_d         (next_instruction),
        .o_q         (instruction)
    );

    // PC+1 is never cleared by a flush; it simply holds.
    pipe_reg #(
        .WIDTH   (PC_W),
        .RST_VAL ('0)
    ) u_pc_reg (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_clear     (1'b0),
        .i_clear_val ('0),
        .i_d         (pc_plus_one_IF),
        .o_q         (pc_plus_one_ID)
    );

    pipe_reg #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_valid_reg (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_clear     (w_flush),
        .i_clear_val (1'b0),
        .i_d         (1'b1),
        .o_q         (valid_ID)
    );

endmodule

// File: tb/tb_if_id.sv
// tb/tb_if_id.sv - self-checking bench for if_id
module tb_if_id;

    localparam int IW = 19;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [IW-1:0] next_instruction;
    logic [PW-1:0] pc_plus_one_IF;
    logic          IF_IDwrite;
    logic          tb_flush;
    logic [IW-1:0] instruction;
    logic [PW-1:0] pc_plus_one_ID;
    logic          valid_ID;

    int tests  = 0;
    int failed = 0;

    // Reference state of the ID-side register.
    logic [IW-1:0] m_instr;
    logic [PW-1:0] m_pc;
    logic          m_valid;

    always #5 clk = ~clk;

    if_id dut (
        .clk              (clk),
        .reset            (reset),
        .next_instruction (next_instruction),
        .pc_plus_one_IF   (pc_plus_one_IF),
        .IF_IDwrite       (IF_IDwrite),
`ifdef IF_ID_FLUSH_EN
        .IF_IDflush       (tb_flush),
`endif
        .instruction      (instruction),
        .pc_plus_one_ID   (pc_plus_one_ID),
        .valid_ID         (valid_ID)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model of what the register holds after one edge with the current inputs.
    task automatic model_edge();
        if (reset === 1'b1) begin
            m_instr = '0;
            m_pc    = '0;
            m_valid = 1'b0;
        end else if (tb_flush === 1'b1) begin
            m_instr = '0;
            m_valid = 1'b0;
        end else if (IF_IDwrite === 1'b1) begin
            m_instr = next_instruction;
            m_pc    = pc_plus_one_IF;
            m_valid = 1'b1;
        end
    endtask

    // Apply current inputs across one rising edge, then compare with the model.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".instr"}, 32'(instruction),    32'(m_instr));
        check({tag, ".pc"},    32'(pc_plus_one_ID), 32'(m_pc));
        check({tag, ".valid"}, 32'(valid_ID),       32'(m_valid));
    endtask

    task automatic drive(input logic rst, input logic wr, input logic fl,
                         input logic [IW-1:0] ins, input logic [PW-1:0] pc);
        reset            = rst;
        IF_IDwrite       = wr;
        tb_flush         = fl;
        next_instruction = ins;
        pc_plus_one_IF   = pc;
    endtask

    initial begin
        m_instr = 'x;
        m_pc    = 'x;
        m_valid = 1'bx;
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        #1;

        // Reset for two edges.
        step("rst0");
        step("rst1");
        check("rst.instr_const", 32'(instruction),    32'd0);
        check("rst.pc_const",    32'(pc_plus_one_ID), 32'd0);
        check("rst.valid_const", 32'(valid_ID),       32'd0);

        // Load 0,1,2 on successive edges, one-edge latency.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, IW'(i), PW'(i));
            step($sformatf("load%0d", i));
            check($sformatf("load%0d.instr_const", i), 32'(instruction), 32'(i));
            check($sformatf("load%0d.valid_const", i), 32'(valid_ID), 32'd1);
        end

        // Stall two edges with changing inputs, then resume.
        drive(1'b0, 1'b0, 1'b0, IW'(3), PW'(3));
        step("stall0");
        drive(1'b0, 1'b0, 1'b0, IW'(4), PW'(4));
        step("stall1");
        check("stall.instr_const", 32'(instruction),    32'd2);
        check("stall.pc_const",    32'(pc_plus_one_ID), 32'd2);
        drive(1'b0, 1'b0, 1'b0, 'x, 'x);
        step("stall_x");
        check("stall_x.instr_const", 32'(instruction), 32'd2);
        drive(1'b0, 1'b1, 1'b0, IW'(5), PW'(5));
        step("resume");
        check("resume.instr_const", 32'(instruction),    32'd5);
        check("resume.pc_const",    32'(pc_plus_one_ID), 32'd5);

`ifdef IF_ID_FLUSH_EN
        drive(1'b0, 1'b1, 1'b0, 19'h7FFFF, 8'hAA);
        step("pre_flush");
        drive(1'b0, 1'b1, 1'b1, IW'(1), PW'(1));
        step("flush");
        check("flush.instr_const", 32'(instruction),    32'd0);
        check("flush.valid_const", 32'(valid_ID),       32'd0);
        check("flush.pc_const",    32'(pc_plus_one_ID), 32'hAA);
        drive(1'b0, 1'b0, 1'b1, IW'(7), PW'(7));
        step("flush_stall");
`endif

        // Reset during a stall overrides the hold.
        drive(1'b0, 1'b1, 1'b0, IW'(3), PW'(3));
        step("pre_stall_rst");
        drive(1'b0, 1'b0, 1'b0, IW'(9), PW'(9));
        step("stall_hold");
        drive(1'b1, 1'b0, 1'b0, IW'(9), PW'(9));
        step("stall_rst");
        check("stall_rst.instr_const", 32'(instruction),    32'd0);
        check("stall_rst.pc_const",    32'(pc_plus_one_ID), 32'd0);
        check("stall_rst.valid_const", 32'(valid_ID),       32'd0);
        drive(1'b1, 1'b1, 1'b0, IW'(8), PW'(8));
        step("rst_over_write");
        drive(1'b0, 1'b1, 1'b0, IW'(6), PW'(6));
        step("post_rst_load");
        check("post_rst.instr_const", 32'(instruction), 32'd6);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic fl;
`ifdef IF_ID_FLUSH_EN
            fl = ($urandom_range(0, 5) == 0);
`else
            fl = 1'b0;
`endif
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0), fl,
                  IW'($urandom), PW'($urandom));
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
